// File: rtl/serial_add_ctrl_if.sv
// Start/result bundle for the bit-serial adder controller.
// The requester drives operands; the adder returns status and result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell iterated LSB first
// with a registered carry, one operand bit per clock.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fs;
  logic             fc;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  fa_cell u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (cy),
    .s  (fs),
    .co (fc)
  );

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum;
  assign bus.c_out = c_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sa    <= bus.a;
            sb    <= bus.b;
            cy    <= bus.c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sr  <= {fs, sr[WIDTH-1:1]};
          cy  <= fc;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          // last bit: publish result together with the DONE pulse
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {fs, sr[WIDTH-1:1]};
            c_out <= fc;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus
// random vectors against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  logic [W-1:0] m_sum;
  logic         m_cout;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full operation from an aligned IDLE point; noise drives
  // START and all-ones operands through RUN and FIN
  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic ci,
                        input bit noise);
    int r;
    int edges;
    int nbusy;
    logic [W-1:0] es;
    logic ec;
    r  = int'(a) + int'(b) + int'(ci);
    es = W'(r);
    ec = r[W];
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
    tick();
    edges = 1;
    nbusy = 0;
    while (!bus.done && edges < 3 * W) begin
      if (bus.busy) begin
        nbusy++;
        check("hold", 32'(bus.sum), 32'(m_sum));
      end
      if (noise) begin
        bus.start = 1'b1;
        bus.a     = '1;
        bus.b     = '1;
        bus.c_in  = 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.c_in  = 1'($urandom);
      end
      tick();
      edges++;
    end
    check("latency", 32'(edges), 32'(W + 1));
    check("busy_len", 32'(nbusy), 32'(W));
    check("overlap", 32'(bus.busy), 32'd0);
    check("sum", 32'(bus.sum), 32'(es));
    check("c_out", 32'(bus.c_out), 32'(ec));
    m_sum  = es;
    m_cout = ec;
    tick();
    check("done_pulse", 32'(bus.done), 32'd0);
    if (noise) begin
      check("fin_ignore", 32'(bus.busy), 32'd0);
      bus.start = 1'b0;
      tick();
      check("no_restart", 32'(bus.busy), 32'd0);
      check("no_restart_done", 32'(bus.done), 32'd0);
      check("sum_kept", 32'(bus.sum), 32'(m_sum));
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int gap;
    int t0;
    int t1;
    int cyc;
    n_chk     = 0;
    n_err     = 0;
    m_sum     = '0;
    m_cout    = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    #35;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 1'b1);
    check("noise_sum", 32'(m_sum), 32'h46);
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    // reset part-way through RUN, off the clock edge
    bus.start = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #4;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_cout", 32'(bus.c_out), 32'd0);
    m_sum  = '0;
    m_cout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < W + 2; i++) begin
      check("no_done_after_rst", 32'(bus.done), 32'd0);
      tick();
    end
    run_op(8'h80, 8'h80, 1'b0, 1'b0);

    // START held high: consecutive completions W+2 cycles apart
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h6B;
    bus.c_in  = 1'b1;
    t0  = -1;
    t1  = -1;
    cyc = 0;
    while (t1 < 0 && cyc < 6 * W) begin
      tick();
      cyc++;
      if (bus.done) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
      end
    end
    bus.start = 1'b0;
    gap = (t0 >= 0 && t1 >= 0) ? t1 - t0 : -1;
    check("b2b_first", 32'(t0), 32'(W + 1));
    check("b2b_gap", 32'(gap), 32'(W + 2));
    check("b2b_sum", 32'(bus.sum), 32'h C6);
    check("b2b_cout", 32'(bus.c_out), 32'd0);
    m_sum  = 8'hC6;
    m_cout = 1'b0;
    tick();

    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
